// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I-subset core.
// Sequences fetch/decode/execute/memory/write-back and counts retired instructions.
module multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             opcode_i,
    input  logic                   mem_ready_i,
    output logic [2:0]             ALU_Op_o,
    output logic [1:0]             ALU_Src_A_o,
    output logic [1:0]             ALU_Src_B_o,
    output logic                   IorD_o,
    output logic                   Mem_Read_o,
    output logic                   Mem_Write_o,
    output logic                   IR_Write_o,
    output logic                   PC_Write_o,
    output logic                   PC_Write_Cond_o,
    output logic                   PC_Src_o,
    output logic                   Reg_Write_o,
    output logic [1:0]             Mem_to_Reg_o,
    output logic                   Instr_Done_o,
    output logic                   Illegal_o,
    output logic [COUNT_WIDTH-1:0] Instr_Count_o
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        EXEC_LUI,
        ALU_WB,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        BRANCH,
        JAL,
        JALR,
        TRAP
    } state_t;

    state_t state;
    state_t next_state;

    logic [COUNT_WIDTH-1:0] count;

    // State register; reset returns to FETCH and aborts any pending access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (Instr_Done_o) begin
            count <= count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign Instr_Count_o = count;
    assign Illegal_o     = (state == TRAP);

    // Next-state and Moore control outputs (ready only qualifies memory states)
    always_comb begin
        next_state      = state;
        ALU_Op_o        = 3'b000;
        ALU_Src_A_o     = 2'b00;
        ALU_Src_B_o     = 2'b00;
        IorD_o          = 1'b0;
        Mem_Read_o      = 1'b0;
        Mem_Write_o     = 1'b0;
        IR_Write_o      = 1'b0;
        PC_Write_o      = 1'b0;
        PC_Write_Cond_o = 1'b0;
        PC_Src_o        = 1'b0;
        Reg_Write_o     = 1'b0;
        Mem_to_Reg_o    = 2'b00;
        Instr_Done_o    = 1'b0;
        unique case (state)
            FETCH: begin
                Mem_Read_o  = 1'b1;
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = 3'b010;
                // Held off during reset so the fetch strobes stay quiet
                IR_Write_o  = mem_ready_i & ~reset;
                PC_Write_o  = mem_ready_i & ~reset;
                if (mem_ready_i) next_state = DECODE;
            end
            DECODE: begin
                ALU_Src_A_o = 2'b10;
                ALU_Src_B_o = 2'b01;
                ALU_Op_o    = 3'b010;
                unique case (opcode_i)
                    OP_R:           next_state = EXEC_R;
                    OP_I:           next_state = EXEC_I;
                    OP_LUI:         next_state = EXEC_LUI;
                    OP_LW, OP_SW:   next_state = MEM_ADDR;
                    OP_B:           next_state = BRANCH;
                    OP_JAL:         next_state = JAL;
                    OP_JALR:        next_state = JALR;
                    default:        next_state = TRAP;
                endcase
            end
            EXEC_R: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b00;
                ALU_Op_o    = 3'b000;
                next_state  = ALU_WB;
            end
            EXEC_I: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b01;
                ALU_Op_o    = 3'b001;
                next_state  = ALU_WB;
            end
            EXEC_LUI: begin
                ALU_Src_B_o = 2'b01;
                ALU_Op_o    = 3'b100;
                next_state  = ALU_WB;
            end
            ALU_WB: begin
                Reg_Write_o  = 1'b1;
                Instr_Done_o = 1'b1;
                next_state   = FETCH;
            end
            MEM_ADDR: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b01;
                ALU_Op_o    = 3'b010;
                next_state  = (opcode_i == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                Mem_Read_o = 1'b1;
                IorD_o     = 1'b1;
                if (mem_ready_i) next_state = MEM_WB;
            end
            MEM_WB: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b01;
                Instr_Done_o = 1'b1;
                next_state   = FETCH;
            end
            MEM_WRITE: begin
                Mem_Write_o  = 1'b1;
                IorD_o       = 1'b1;
                Instr_Done_o = mem_ready_i & ~reset;
                if (mem_ready_i) next_state = FETCH;
            end
            BRANCH: begin
                ALU_Src_A_o     = 2'b01;
                ALU_Src_B_o     = 2'b00;
                ALU_Op_o        = 3'b101;
                PC_Write_Cond_o = 1'b1;
                PC_Src_o        = 1'b1;
                Instr_Done_o    = 1'b1;
                next_state      = FETCH;
            end
            JAL: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b10;
                PC_Write_o   = 1'b1;
                PC_Src_o     = 1'b1;
                Instr_Done_o = 1'b1;
                next_state   = FETCH;
            end
            JALR: begin
                ALU_Src_A_o  = 2'b01;
                ALU_Src_B_o  = 2'b01;
                ALU_Op_o     = 3'b111;
                PC_Write_o   = 1'b1;
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b10;
                Instr_Done_o = 1'b1;
                next_state   = FETCH;
            end
            TRAP: begin
                next_state = TRAP;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default-width and 4-bit-counter
// instances share stimulus; expected values are hand-derived per cycle.
module tb_multicycle_control;

    localparam logic [6:0] R    = 7'b0110011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JALI = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        mem_ready;

    logic [2:0]  alu_op;
    logic [1:0]  src_a, src_b, m2r;
    logic        iord, mem_read, mem_write, ir_write, pc_write;
    logic        pc_wc, pc_src, reg_write, done, illegal;
    logic [31:0] count;

    logic [2:0]  s_alu_op;
    logic [1:0]  s_src_a, s_src_b, s_m2r;
    logic        s_iord, s_mem_read, s_mem_write, s_ir_write, s_pc_write;
    logic        s_pc_wc, s_pc_src, s_reg_write, s_done, s_illegal;
    logic [3:0]  s_count;

    int errors = 0;
    int checks = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .ALU_Op_o(alu_op), .ALU_Src_A_o(src_a), .ALU_Src_B_o(src_b),
        .IorD_o(iord), .Mem_Read_o(mem_read), .Mem_Write_o(mem_write),
        .IR_Write_o(ir_write), .PC_Write_o(pc_write),
        .PC_Write_Cond_o(pc_wc), .PC_Src_o(pc_src),
        .Reg_Write_o(reg_write), .Mem_to_Reg_o(m2r),
        .Instr_Done_o(done), .Illegal_o(illegal), .Instr_Count_o(count)
    );

    multicycle_control #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .ALU_Op_o(s_alu_op), .ALU_Src_A_o(s_src_a), .ALU_Src_B_o(s_src_b),
        .IorD_o(s_iord), .Mem_Read_o(s_mem_read), .Mem_Write_o(s_mem_write),
        .IR_Write_o(s_ir_write), .PC_Write_o(s_pc_write),
        .PC_Write_Cond_o(s_pc_wc), .PC_Src_o(s_pc_src),
        .Reg_Write_o(s_reg_write), .Mem_to_Reg_o(s_m2r),
        .Instr_Done_o(s_done), .Illegal_o(s_illegal), .Instr_Count_o(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then drive inputs and settle mid-cycle
    task automatic step(input logic rdy, input logic [6:0] op);
        @(posedge clk);
        #2;
        mem_ready = rdy;
        opcode    = op;
        #1;
    endtask

    // Release reset inside a cycle; that cycle is the first FETCH
    task automatic release_reset(input logic rdy, input logic [6:0] op);
        @(posedge clk);
        #2;
        reset     = 1'b0;
        mem_ready = rdy;
        opcode    = op;
        #1;
    endtask

    // Run a zero-wait instruction whose FETCH is the current cycle
    task automatic run_plain(input logic [6:0] op, input int len);
        for (int i = 1; i < len; i++) step(1'b1, op);
        chk("plain_done", {31'b0, done}, 32'd1);
        step(1'b1, op);
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 7'b0;
        #7;
        chk("rst_mem_read", {31'b0, mem_read}, 32'd1);
        chk("rst_src_b", {30'b0, src_b}, 32'd2);
        chk("rst_alu_op", {29'b0, alu_op}, 32'd2);
        chk("rst_ir_write", {31'b0, ir_write}, 32'd0);
        chk("rst_reg_write", {31'b0, reg_write}, 32'd0);
        chk("rst_count", count, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);

        // R-type, zero wait: cycles 1..4
        release_reset(1'b1, R);
        chk("r_c1_ir_write", {31'b0, ir_write}, 32'd1);
        chk("r_c1_pc_write", {31'b0, pc_write}, 32'd1);
        step(1'b1, R);
        chk("r_c2_src_a", {30'b0, src_a}, 32'd2);
        chk("r_c2_src_b", {30'b0, src_b}, 32'd1);
        chk("r_c2_mem_read", {31'b0, mem_read}, 32'd0);
        step(1'b1, R);
        chk("r_c3_alu_op", {29'b0, alu_op}, 32'd0);
        chk("r_c3_src_a", {30'b0, src_a}, 32'd1);
        chk("r_c3_done", {31'b0, done}, 32'd0);
        step(1'b1, R);
        chk("r_c4_reg_write", {31'b0, reg_write}, 32'd1);
        chk("r_c4_m2r", {30'b0, m2r}, 32'd0);
        chk("r_c4_done", {31'b0, done}, 32'd1);
        chk("r_c4_count", count, 32'd0);

        // LW: FETCH waits 2, MEM_READ waits 3, Done on relative cycle 10
        step(1'b0, LW);
        chk("lw_c1_count", count, 32'd1);
        chk("lw_c1_mem_read", {31'b0, mem_read}, 32'd1);
        chk("lw_c1_ir_write", {31'b0, ir_write}, 32'd0);
        step(1'b0, LW);
        chk("lw_c2_mem_read", {31'b0, mem_read}, 32'd1);
        chk("lw_c2_pc_write", {31'b0, pc_write}, 32'd0);
        step(1'b1, LW);
        chk("lw_c3_ir_write", {31'b0, ir_write}, 32'd1);
        step(1'b1, LW);
        chk("lw_c4_decode_src_a", {30'b0, src_a}, 32'd2);
        step(1'b0, LW);
        chk("lw_c5_addr_alu_op", {29'b0, alu_op}, 32'd2);
        chk("lw_c5_addr_src_b", {30'b0, src_b}, 32'd1);
        chk("lw_c5_mem_read", {31'b0, mem_read}, 32'd0);
        for (int i = 6; i <= 8; i++) begin
            step(1'b0, LW);
            chk("lw_wait_mem_read", {31'b0, mem_read}, 32'd1);
            chk("lw_wait_iord", {31'b0, iord}, 32'd1);
            chk("lw_wait_done", {31'b0, done}, 32'd0);
        end
        step(1'b1, LW);
        chk("lw_c9_mem_read", {31'b0, mem_read}, 32'd1);
        chk("lw_c9_done", {31'b0, done}, 32'd0);
        step(1'b1, LW);
        chk("lw_c10_done", {31'b0, done}, 32'd1);
        chk("lw_c10_m2r", {30'b0, m2r}, 32'd1);
        chk("lw_c10_reg_write", {31'b0, reg_write}, 32'd1);

        // SW, BEQ, JAL, JALR back to back: Done at 4, 7, 10, 13
        step(1'b1, SW);
        chk("sw_c1_count", count, 32'd2);
        step(1'b1, SW);
        step(1'b1, SW);
        step(1'b1, SW);
        chk("sw_mem_write", {31'b0, mem_write}, 32'd1);
        chk("sw_iord", {31'b0, iord}, 32'd1);
        chk("sw_done", {31'b0, done}, 32'd1);
        step(1'b1, BEQ);
        step(1'b1, BEQ);
        step(1'b1, BEQ);
        chk("beq_alu_op", {29'b0, alu_op}, 32'd5);
        chk("beq_pc_wc", {31'b0, pc_wc}, 32'd1);
        chk("beq_pc_src", {31'b0, pc_src}, 32'd1);
        chk("beq_done", {31'b0, done}, 32'd1);
        step(1'b1, JALI);
        step(1'b1, JALI);
        step(1'b1, JALI);
        chk("jal_m2r", {30'b0, m2r}, 32'd2);
        chk("jal_pc_write", {31'b0, pc_write}, 32'd1);
        chk("jal_pc_src", {31'b0, pc_src}, 32'd1);
        chk("jal_done", {31'b0, done}, 32'd1);
        step(1'b1, JALR);
        step(1'b1, JALR);
        step(1'b1, JALR);
        chk("jalr_alu_op", {29'b0, alu_op}, 32'd7);
        chk("jalr_pc_src", {31'b0, pc_src}, 32'd0);
        chk("jalr_reg_write", {31'b0, reg_write}, 32'd1);
        chk("jalr_done", {31'b0, done}, 32'd1);

        // SW with one MEM_WRITE wait: Done only on the ready cycle
        step(1'b1, SW);
        chk("sw2_count", count, 32'd6);
        step(1'b1, SW);
        step(1'b1, SW);
        step(1'b0, SW);
        chk("sw2_wait_mem_write", {31'b0, mem_write}, 32'd1);
        chk("sw2_wait_done", {31'b0, done}, 32'd0);
        step(1'b1, SW);
        chk("sw2_ready_mem_write", {31'b0, mem_write}, 32'd1);
        chk("sw2_ready_done", {31'b0, done}, 32'd1);

        // Illegal opcode traps until reset
        step(1'b1, BAD);
        chk("bad_c1_count", count, 32'd7);
        step(1'b1, BAD);
        chk("bad_c2_illegal", {31'b0, illegal}, 32'd0);
        step(1'b1, BAD);
        chk("trap_illegal", {31'b0, illegal}, 32'd1);
        chk("trap_mem_read", {31'b0, mem_read}, 32'd0);
        step(1'b1, R);
        chk("trap_hold_illegal", {31'b0, illegal}, 32'd1);
        chk("trap_hold_mem_read", {31'b0, mem_read}, 32'd0);
        chk("trap_hold_ir_write", {31'b0, ir_write}, 32'd0);
        chk("trap_hold_count", count, 32'd7);
        #1;
        reset = 1'b1;
        #1;
        chk("trap_rst_illegal", {31'b0, illegal}, 32'd0);
        chk("trap_rst_mem_read", {31'b0, mem_read}, 32'd1);
        chk("trap_rst_count", count, 32'd0);

        // One R, then reset during an LW MEM_READ wait
        release_reset(1'b1, R);
        run_plain(R, 4);
        chk("abort_pre_count", count, 32'd1);
        step(1'b1, LW);
        step(1'b1, LW);
        step(1'b0, LW);
        chk("abort_wait_iord", {31'b0, iord}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_iord", {31'b0, iord}, 32'd0);
        chk("abort_mem_read", {31'b0, mem_read}, 32'd1);
        chk("abort_src_b", {30'b0, src_b}, 32'd2);
        chk("abort_alu_op", {29'b0, alu_op}, 32'd2);
        chk("abort_count", count, 32'd0);

        // 16 LUIs: 4-bit counter wraps to 0, 32-bit reaches 16
        release_reset(1'b1, LUI);
        step(1'b1, LUI);
        step(1'b1, LUI);
        chk("lui_alu_op", {29'b0, alu_op}, 32'd4);
        chk("lui_src_a", {30'b0, src_a}, 32'd0);
        chk("lui_src_b", {30'b0, src_b}, 32'd1);
        step(1'b1, LUI);
        chk("lui_done", {31'b0, done}, 32'd1);
        step(1'b1, LUI);
        for (int k = 1; k < 16; k++) run_plain(LUI, 4);
        chk("wrap_count4", {28'b0, s_count}, 32'd0);
        chk("wrap_count32", count, 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle variant of the RISC-V core; sits directly upstream of the ALU control decoder and drives its 3-bit ALU op. It sequences each RV32I-subset instruction through fetch, decode, execute, memory and write-back states. It stalls on a shared instruction/data memory ready handshake, flags unsupported opcodes, and counts retired instructions.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode_i  in  7  instruction register bits [6:0], valid from DECODE onward
- mem_ready_i  in  1  memory has completed the current read/write this cycle
- ALU_Op_o  out  3  to ALU control: 000 R, 001 I-arith, 010 add (ld/st/addr), 100 LUI, 101 branch, 111 JALR
- ALU_Src_A_o  out  2  00 PC, 01 rs1, 10 old PC (PC of current instruction)
- ALU_Src_B_o  out  2  00 rs2, 01 imm, 10 constant 4
- IorD_o  out  1  memory address: 0 PC, 1 ALUOut
- Mem_Read_o / Mem_Write_o  out  1 each  memory request, held until mem_ready_i
- IR_Write_o  out  1  load instruction register
- PC_Write_o  out  1  unconditional PC update
- PC_Write_Cond_o  out  1  PC update qualified by ALU branch result
- PC_Src_o  out  1  0 ALU result, 1 ALUOut register
- Reg_Write_o  out  1  register-file write enable
- Mem_to_Reg_o  out  2  00 ALUOut, 01 memory data register, 10 PC
- Instr_Done_o  out  1  one-cycle pulse in final state of each instruction
- Illegal_o  out  1  sticky: unsupported opcode decoded
- Instr_Count_o  out  COUNT_WIDTH  retired instructions

## Operation
- Opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111. Any other value: illegal.
- Moore outputs; all controls 0 unless listed.
- FETCH: Mem_Read=1, IorD=0, A=00, B=10, ALU_Op=010; IR_Write=PC_Write=mem_ready_i, PC_Src=0. Stay until mem_ready_i=1, then DECODE.
- DECODE: A=10, B=01, ALU_Op=010 (branch/JAL target into ALUOut). Next: R→EXEC_R, I→EXEC_I, LUI→EXEC_LUI, LW/SW→MEM_ADDR, B→BRANCH, JAL→JAL, JALR→JALR, else TRAP.
- EXEC_R: A=01, B=00, Op=000. EXEC_I: A=01, B=01, Op=001. EXEC_LUI: B=01, Op=100. All three → ALU_WB.
- ALU_WB: Reg_Write=1, Mem_to_Reg=00, Done → FETCH.
- MEM_ADDR: A=01, B=01, Op=010 → MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: Mem_Read=1, IorD=1; wait for ready → MEM_WB.
- MEM_WB: Reg_Write=1, Mem_to_Reg=01, Done → FETCH.
- MEM_WRITE: Mem_Write=1, IorD=1; Done asserted only in the cycle mem_ready_i=1 → FETCH.
- BRANCH: A=01, B=00, Op=101, PC_Write_Cond=1, PC_Src=1, Done → FETCH.
- JAL: Reg_Write=1, Mem_to_Reg=10, PC_Write=1, PC_Src=1, Done → FETCH.
- JALR: A=01, B=01, Op=111, PC_Write=1, PC_Src=0, Reg_Write=1, Mem_to_Reg=10, Done → FETCH.
- TRAP: all controls 0, Illegal_o=1; stays until reset.
- Instr_Count_o increments on every Done cycle and wraps modulo 2^COUNT_WIDTH.

## Timing
- Reset asserted: state=FETCH, Illegal_o=0, Instr_Count_o=0. Outputs take FETCH values asynchronously: Mem_Read=1, B=10, ALU_Op=010; others 0.
- Reset mid-wait aborts the pending memory access; FETCH restarts on the first edge after deassertion.
- Zero-wait latency (FETCH to Done inclusive): R/I/LUI/SW 4, LW 5, B/JAL/JALR 3 cycles. Each wait cycle adds 1 to FETCH, MEM_READ or MEM_WRITE.
- mem_ready_i is ignored outside FETCH/MEM_READ/MEM_WRITE.
- Mem_Read/Mem_Write remain stable from entry until the ready cycle inclusive.

## Test plan
- Reset, ready tied 1, R opcode 0110011: states FETCH,DECODE,EXEC_R,ALU_WB; Reg_Write in cycle 4, ALU_Op 000 in cycle 3, count=1.
- LW with mem_ready_i low 2 cycles in FETCH and 3 in MEM_READ: Done at cycle 10; Mem_Read held high through each wait; IR_Write only on ready.
- Back-to-back SW, BEQ, JAL, JALR: Done at cycles 4, 7, 10, 13; BRANCH ALU_Op=101 with PC_Write_Cond=1; JALR ALU_Op=111; count=4.
- Opcode 1111111: DECODE→TRAP, Illegal_o=1, no further memory requests; assert reset → Illegal_o=0, FETCH.
- Reset asserted during MEM_READ wait: outputs return to FETCH values immediately, count=0.
- COUNT_WIDTH=4, 16 LUI instructions: Instr_Count_o wraps to 0.
